// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// producing a registered one-cycle write-back strobe for the register file.
module exec_stage #(
  parameter  int DATA_WIDTH = 8,
  localparam int SH_W       = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            rd,
  output logic                  wb_en,
  output logic [2:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_zero,
  output logic [1:0]            dbg_state
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready;
  // in_valid while in_ready=0 is ignored and the issuer must hold the op.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_WB = 2'd2} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  state_t                state_q, state_d;
  logic [SH_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [2:0]            mrd_q, mrd_d;
  logic                  wb_en_q, wb_en_d;
  logic [2:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] acc_nxt;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << b[SH_W-1:0];
      OP_SHR:  alu_res = a >> b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mrd_d     = mrd_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    in_ready  = (state_q == S_IDLE);
    acc_nxt   = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            mrd_d    = rd;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            // r0 is hard-wired zero: result still lands on wb_rd/wb_data, strobe suppressed
            wb_en_d   = (rd != 3'd0);
            wb_rd_d   = rd;
            wb_data_d = alu_res;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(DATA_WIDTH - 1)) begin
          state_d   = S_WB;
          wb_en_d   = (mrd_q != 3'd0);
          wb_rd_d   = mrd_q;
          wb_data_d = acc_nxt;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      mrd_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      mrd_q     <= mrd_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_zero   = wb_en_q && (wb_data_q == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: inputs change on the falling edge, outputs
// are checked on the falling edge, results are hand-computed constants.
module tb_exec_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] rd;
  logic       wb_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_zero;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .rd(rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] r);
    in_valid = v; op = o; a = x; b = y; rd = r;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [2:0] r,
                        input logic [7:0] d, input logic z);
    chk({tag, "_en"},   32'(wb_en),   32'(en));
    chk({tag, "_rd"},   32'(wb_rd),   32'(r));
    chk({tag, "_data"}, 32'(wb_data), 32'(d));
    chk({tag, "_zero"}, 32'(wb_zero), 32'(z));
  endtask

  // Issue a MUL at the coming edge N, then check the 9 busy cycles and the single pulse.
  task automatic do_mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] r, input logic [7:0] exp);
    drive(1'b1, 3'd7, x, y, r);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
    for (int i = 1; i <= 9; i++) begin
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_en"}, 32'(wb_en), (i == 9) ? 32'd1 : 32'd0);
      if (i == 9) begin
        chk({tag, "_rd"}, 32'(wb_rd), 32'(r));
        chk({tag, "_data"}, 32'(wb_data), 32'(exp));
      end
      @(negedge clk);
    end
    chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_en_after"}, 32'(wb_en), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
    repeat (2) @(negedge clk);
    chk_wb("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk_wb("reset_rel", 1'b0, 3'd0, 8'h00, 1'b0);

    // 1: ADD wraps modulo 256
    drive(1'b1, 3'd0, 8'd200, 8'd100, 3'd3);
    @(negedge clk);
    chk_wb("add", 1'b1, 3'd3, 8'd44, 1'b0);

    // 2: SUB to zero then XOR, back to back
    drive(1'b1, 3'd1, 8'd5, 8'd5, 3'd1);
    @(negedge clk);
    chk_wb("sub0", 1'b1, 3'd1, 8'h00, 1'b1);
    drive(1'b1, 3'd4, 8'hF0, 8'h0F, 3'd2);
    @(negedge clk);
    chk_wb("xor", 1'b1, 3'd2, 8'hFF, 1'b0);
    drive(1'b1, 3'd1, 8'd3, 8'd5, 3'd5);
    @(negedge clk);
    chk_wb("sub_neg", 1'b1, 3'd5, 8'hFE, 1'b0);
    drive(1'b1, 3'd2, 8'hCC, 8'hAA, 3'd6);
    @(negedge clk);
    chk_wb("and", 1'b1, 3'd6, 8'h88, 1'b0);
    drive(1'b1, 3'd3, 8'hC0, 8'h0A, 3'd7);
    @(negedge clk);
    chk_wb("or", 1'b1, 3'd7, 8'hCA, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    chk("idle_en", 32'(wb_en), 32'd0);

    // 3: MUL 13*11, and 255*255 low byte
    do_mul("mul13x11", 8'd13, 8'd11, 3'd4, 8'h8F);
    do_mul("mul255", 8'hFF, 8'hFF, 3'd7, 8'h01);

    // 4: MUL 20*20 with an ADD held on the inputs while busy
    drive(1'b1, 3'd7, 8'd20, 8'd20, 3'd5);
    @(negedge clk);
    drive(1'b1, 3'd0, 8'd1, 8'd2, 3'd6);
    for (int i = 1; i <= 9; i++) begin
      chk("mul20_busy", 32'(in_ready), 32'd0);
      chk("mul20_en", 32'(wb_en), (i == 9) ? 32'd1 : 32'd0);
      if (i == 9) begin
        chk("mul20_rd", 32'(wb_rd), 32'd5);
        chk("mul20_data", 32'(wb_data), 32'h90);
      end
      @(negedge clk);
    end
    chk("held_ready", 32'(in_ready), 32'd1);
    chk("held_en_pre", 32'(wb_en), 32'd0);
    @(negedge clk);
    chk_wb("held_add", 1'b1, 3'd6, 8'd3, 1'b0);

    // 5: shifts use only b[2:0]; rd=0 suppresses the strobe
    drive(1'b1, 3'd5, 8'h81, 8'h09, 3'd1);
    @(negedge clk);
    chk_wb("shl", 1'b1, 3'd1, 8'h02, 1'b0);
    drive(1'b1, 3'd6, 8'h80, 8'd7, 3'd2);
    @(negedge clk);
    chk_wb("shr", 1'b1, 3'd2, 8'h01, 1'b0);
    drive(1'b1, 3'd0, 8'd3, 8'd4, 3'd0);
    @(negedge clk);
    chk_wb("rd0", 1'b0, 3'd0, 8'd7, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);

    // 6: reset during MUL aborts it
    drive(1'b1, 3'd7, 8'd13, 8'd11, 3'd4);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_wb("abort_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_en", 32'(wb_en), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
